// File: rtl/result_drain_pkg.sv
// result_drain shared types: drain FSM states
// and the output word width helper.
package result_drain_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CAPTURE,
    STREAM
  } drain_state_t;

  // One word is four lanes of 4*dw bits.
  function automatic int word_w(input int dw);
    return 16 * dw;
  endfunction

endpackage

// File: rtl/result_drain_if.sv
// Output valid/ready stream of the drain.
// master drives out_valid/out_data/out_last; slave drives out_ready.
interface result_drain_if #(
  parameter int DATA_WIDTH = 8
);
  import result_drain_pkg::*;

  localparam int WW = word_w(DATA_WIDTH);

  logic          out_valid;
  logic          out_ready;
  logic [WW-1:0] out_data;
  logic          out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/result_drain_buf.sv
// CHAIN_LEN-deep word buffer: one sync write port, one async read port.
// Ports: clk_i, we_i/waddr_i/wdata_i (write), raddr_i/rdata_o (read).
module result_drain_buf
  import result_drain_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CHAIN_LEN  = 4
) (
  input  logic                         clk_i,
  input  logic                         we_i,
  input  logic [$clog2(CHAIN_LEN)-1:0] waddr_i,
  input  logic [word_w(DATA_WIDTH)-1:0] wdata_i,
  input  logic [$clog2(CHAIN_LEN)-1:0] raddr_i,
  output logic [word_w(DATA_WIDTH)-1:0] rdata_o
);

  localparam int WW = word_w(DATA_WIDTH);

  // Storage is overwritten before it is read, so it carries no reset.
  logic [WW-1:0] mem_q [CHAIN_LEN];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/result_drain.sv
// Drains the PE result chain tail into a buffer, then streams it out.
// Ports: Clk, rst, start, ResultIn_0..3, ResultCapture, busy, done, out_if.
module result_drain
  import result_drain_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CHAIN_LEN  = 4
) (
  input  logic                    Clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [4*DATA_WIDTH-1:0] ResultIn_0,
  input  logic [4*DATA_WIDTH-1:0] ResultIn_1,
  input  logic [4*DATA_WIDTH-1:0] ResultIn_2,
  input  logic [4*DATA_WIDTH-1:0] ResultIn_3,
  output logic                    ResultCapture,
  output logic                    busy,
  output logic                    done,
  result_drain_if.master          out_if
);

  localparam int WW = word_w(DATA_WIDTH);
  localparam int CW = $clog2(CHAIN_LEN);
  localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);

  drain_state_t  state_q, state_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic          done_q, done_d;
  logic          we;
  logic [WW-1:0] rdata;

  result_drain_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .CHAIN_LEN (CHAIN_LEN)
  ) u_buf (
    .clk_i  (Clk),
    .we_i   (we),
    .waddr_i(wcnt_q),
    .wdata_i({ResultIn_3, ResultIn_2, ResultIn_1, ResultIn_0}),
    .raddr_i(rcnt_q),
    .rdata_o(rdata)
  );

  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      rcnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    rcnt_d  = rcnt_q;
    done_d  = 1'b0;
    we      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        wcnt_d  = '0;
        state_d = CAPTURE;
      end
      CAPTURE: begin
        we = 1'b1;
        // Hold wcnt on the last write so it never wraps.
        if (wcnt_q == LAST) begin
          rcnt_d  = '0;
          state_d = STREAM;
        end else begin
          wcnt_d = wcnt_q + CW'(1);
        end
      end
      STREAM: begin
        if (out_if.out_ready) begin
          if (rcnt_q == LAST) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            rcnt_d = rcnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Decoded from state/counters only; out_ready never reaches an output.
  always_comb begin
    ResultCapture    = (state_q != LOAD);
    busy             = (state_q != IDLE);
    done             = done_q;
    out_if.out_valid = (state_q == STREAM);
    out_if.out_last  = (state_q == STREAM) && (rcnt_q == LAST);
    out_if.out_data  = (state_q == STREAM) ? rdata : '0;
  end

endmodule

// File: tb/tb_result_drain.sv
// Directed bench for result_drain.
// Hand-written words per drain; one check task for every compare.
module tb_result_drain;

  logic        Clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] ri0, ri1, ri2, ri3;
  logic        ResultCapture;
  logic        busy;
  logic        done;

  result_drain_if #(.DATA_WIDTH(8)) dif ();

  result_drain #(
    .DATA_WIDTH(8),
    .CHAIN_LEN (4)
  ) dut (
    .Clk          (Clk),
    .rst          (rst),
    .start        (start),
    .ResultIn_0   (ri0),
    .ResultIn_1   (ri1),
    .ResultIn_2   (ri2),
    .ResultIn_3   (ri3),
    .ResultCapture(ResultCapture),
    .busy         (busy),
    .done         (done),
    .out_if       (dif)
  );

  always #5 Clk = ~Clk;

  int nchk = 0;
  int nerr = 0;
  logic [127:0] wv [4];

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic kick();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_rc"}, ResultCapture, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, dif.out_valid, 0);
    chk({tag, "_data"}, dif.out_data, 0);
    chk({tag, "_last"}, dif.out_last, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic load_chk();
    chk("load_rc", ResultCapture, 0);
    chk("load_busy", busy, 1);
    chk("load_valid", dif.out_valid, 0);
    cyc();
  endtask

  task automatic capture(input int pulse);
    for (int i = 0; i < 4; i++) begin
      {ri3, ri2, ri1, ri0} = wv[i];
      start = (i == pulse);
      chk("cap_rc", ResultCapture, 1);
      chk("cap_valid", dif.out_valid, 0);
      chk("cap_busy", busy, 1);
      cyc();
    end
    start = 1'b0;
  endtask

  task automatic stream(input int stall, input int pulse, input bit b2b);
    dif.out_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      chk("stall_valid", dif.out_valid, 1);
      chk("stall_data", dif.out_data, wv[0]);
      chk("stall_last", dif.out_last, 0);
      cyc();
    end
    dif.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      start = (k == pulse);
      chk("str_valid", dif.out_valid, 1);
      chk("str_data", dif.out_data, wv[k]);
      chk("str_last", dif.out_last, (k == 3));
      chk("str_done", done, 0);
      cyc();
    end
    start = b2b;
    chk("done_hi", done, 1);
    chk("done_busy", busy, 0);
    chk("done_valid", dif.out_valid, 0);
    cyc();
    start = 1'b0;
    if (!b2b) begin
      chk("done_lo", done, 0);
      chk("idle_busy", busy, 0);
      chk("idle_rc", ResultCapture, 1);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    {ri3, ri2, ri1, ri0} = '0;
    dif.out_ready = 1'b1;
    repeat (2) cyc();
    rst_chk("reset");
    rst = 1'b0;
    cyc();
    rst_chk("idle");

    // Basic drain
    wv[0] = 128'h300000A0_200000A0_100000A0_000000A0;
    wv[1] = 128'h300000A1_200000A1_100000A1_000000A1;
    wv[2] = 128'h300000A2_200000A2_100000A2_000000A2;
    wv[3] = 128'h300000A3_200000A3_100000A3_000000A3;
    kick();
    load_chk();
    capture(-1);
    stream(0, -1, 1'b0);

    // Backpressure on word 0
    wv[0] = 128'h0000B000_1111B000_2222B000_3333B000;
    wv[1] = 128'h0000B001_1111B001_2222B001_3333B001;
    wv[2] = 128'h0000B002_1111B002_2222B002_3333B002;
    wv[3] = 128'h0000B003_1111B003_2222B003_3333B003;
    kick();
    load_chk();
    capture(-1);
    stream(3, -1, 1'b0);

    // Start while busy is ignored
    wv[0] = 128'hC0C0C0C0_0C0C0C0C_C0000000_0000000C;
    wv[1] = 128'hC1C1C1C1_1C1C1C1C_C1000000_0000001C;
    wv[2] = 128'hC2C2C2C2_2C2C2C2C_C2000000_0000002C;
    wv[3] = 128'hC3C3C3C3_3C3C3C3C_C3000000_0000003C;
    kick();
    load_chk();
    capture(1);
    stream(0, 1, 1'b0);
    cyc();
    chk("nostart_busy", busy, 0);

    // Back-to-back: start in the done cycle
    wv[0] = 128'hD0000000_D0000001_D0000002_D0000003;
    wv[1] = 128'hD1000000_D1000001_D1000002_D1000003;
    wv[2] = 128'hD2000000_D2000001_D2000002_D2000003;
    wv[3] = 128'hD3000000_D3000001_D3000002_D3000003;
    kick();
    load_chk();
    capture(-1);
    stream(0, -1, 1'b1);
    wv[0] = 128'hE0E0E0E0_E1E1E1E1_E2E2E2E2_E3E3E3E3;
    wv[1] = 128'hE4E4E4E4_E5E5E5E5_E6E6E6E6_E7E7E7E7;
    wv[2] = 128'hE8E8E8E8_E9E9E9E9_EAEAEAEA_EBEBEBEB;
    wv[3] = 128'hECECECEC_EDEDEDED_EEEEEEEE_EFEFEFEF;
    load_chk();
    capture(-1);
    stream(0, -1, 1'b0);

    // Reset mid-stream after two handshakes
    wv[0] = 128'hF0F0F0F0_00000000_11111111_22222222;
    wv[1] = 128'hF1F1F1F1_33333333_44444444_55555555;
    wv[2] = 128'hF2F2F2F2_66666666_77777777_88888888;
    wv[3] = 128'hF3F3F3F3_99999999_AAAAAAAA_BBBBBBBB;
    kick();
    load_chk();
    capture(-1);
    dif.out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      chk("pre_rst_data", dif.out_data, wv[k]);
      cyc();
    end
    chk("pre_rst_word2", dif.out_data, wv[2]);
    #2 rst = 1'b1;
    #1 rst_chk("midrst");
    rst = 1'b0;
    cyc();
    chk("midrst_nodone", done, 0);
    chk("midrst_idle", busy, 0);
    kick();
    load_chk();
    capture(-1);
    stream(0, -1, 1'b0);

    // Lane packing, lane3 in the MSBs
    wv[0] = 128'h7FFFFFFE_80000001_00000000_FFFFFFFF;
    wv[1] = 128'hFFFFFFFF_00000000_80000001_7FFFFFFE;
    wv[2] = 128'h00000000_FFFFFFFF_7FFFFFFE_80000001;
    wv[3] = 128'h80000001_7FFFFFFE_FFFFFFFF_00000000;
    kick();
    load_chk();
    capture(-1);
    chk("lane3_msb", dif.out_data[127:96], 32'h7FFFFFFE);
    chk("lane0_lsb", dif.out_data[31:0], 32'hFFFFFFFF);
    stream(0, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/result_drain.md
# result_drain

Drain controller at the tail of the result daisy-chain of PE result-select stages. On `start` it issues a one-cycle local-load (`ResultCapture`=0), then holds shift mode and captures one 4-lane word per cycle from the chain tail into a CHAIN_LEN-deep buffer. The buffered words then stream to the output writer over a valid/ready interface.

## Interface
- `DATA_WIDTH`, 8: element width; one lane is 4*DATA_WIDTH; one word is 16*DATA_WIDTH.
- `CHAIN_LEN`, 4: number of result-select stages in the chain; ≥2.
- `Clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  PE results ready; sampled only in IDLE.
- `ResultIn_0`..`ResultIn_3`  in  4*DATA_WIDTH each  lanes from the chain-tail stage outputs.
- `ResultCapture`  out  1  chain mode: 0 = load local, 1 = shift.
- `busy`  out  1  high in every state except IDLE.
- `out_valid`  out  1  `out_data` holds a valid word.
- `out_ready`  in  1  consumer accepts the word.
- `out_data`  out  16*DATA_WIDTH  {lane3, lane2, lane1, lane0}.
- `out_last`  out  1  high with the final word of a drain.
- `done`  out  1  one-cycle pulse after the final handshake.

## Operation
- FSM states: IDLE, LOAD, CAPTURE, STREAM.
- IDLE: `ResultCapture`=1. If `start`=1 at an edge, go to LOAD.
- LOAD, exactly one cycle: `ResultCapture`=0. The chain loads its local results at the next edge. Clear the capture counter `wcnt`. Go to CAPTURE.
- CAPTURE, exactly CHAIN_LEN cycles: `ResultCapture`=1. At each edge, write {ResultIn_3..0} to `buf[wcnt]` and increment `wcnt`. Word i is the local result of stage CHAIN_LEN-1-i (tail stage first). When the write at `wcnt`=CHAIN_LEN-1 completes, clear `rcnt` and go to STREAM.
- The chain cannot stall, so there is no backpressure during CAPTURE. `out_ready` is ignored outside STREAM.
- STREAM: `out_valid`=1 and `out_data`=`buf[rcnt]`. `out_last`=1 when `rcnt`=CHAIN_LEN-1.
  - A handshake (`out_valid`&`out_ready` at an edge) increments `rcnt`.
  - A handshake with `out_last`=1 goes to IDLE and sets `done` for the next cycle.
- `start` while busy is ignored; it is not queued.
- `start` in the cycle `done` is high is accepted normally.
- `out_ready` low in STREAM stalls indefinitely. `out_data` and `out_last` stay stable while stalled.
- Counters are $clog2(CHAIN_LEN) bits wide and never wrap mid-drain. No arithmetic is done on the data; it passes through bit-exact.

## Timing
- Reset values: `ResultCapture`=1, `busy`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `done`=0. State is IDLE, counters are 0, buffer contents are don't-care.
- Reset asserted mid-drain forces IDLE asynchronously and discards buffered words. No `done` is issued.
- `start` sampled at edge E0 gives this sequence:
  - LOAD, with `ResultCapture`=0, in cycle E0→E1.
  - Buffer writes at edges E2..E(1+CHAIN_LEN).
  - `out_valid` high from E(1+CHAIN_LEN). For CHAIN_LEN=4 this is 5 cycles after the `start` edge.
- With `out_ready` tied high, STREAM lasts CHAIN_LEN cycles. `done` is high in the cycle after the last handshake. Minimum start-to-start spacing is 2+2*CHAIN_LEN cycles.
- All outputs are registered or decoded directly from state and counters. There is no combinational path from `out_ready` to any output.

## Structure
- `result_drain_pkg`: state enum `drain_state_t` (IDLE, LOAD, CAPTURE, STREAM) and a localparam function for word width (16*DATA_WIDTH).
- Sub-module `result_drain_buf`: CHAIN_LEN × 16*DATA_WIDTH register file. It has one synchronous write port and one asynchronous read port, with no reset on its storage.
- The top level holds the FSM, `wcnt`/`rcnt`, the output decode and the `done` register.

## Test plan
- Basic drain, CHAIN_LEN=4, `out_ready`=1. Tail presents 0x…A0, A1, A2, A3 in CAPTURE cycles 0–3. Expected:
  - `ResultCapture`=0 for exactly one cycle.
  - Outputs A0..A3 in order, `out_last` on A3.
  - `done` one cycle after A3.
- Backpressure: `out_ready` low for 3 cycles after `out_valid` rises. Expected: word 0 held stable for 3 cycles; all 4 words delivered with no loss or duplication.
- Start while busy: pulse `start` during CAPTURE and again during STREAM. Expected: no extra LOAD cycle; exactly 4 words; one `done`.
- Back-to-back: `start` high in the `done` cycle. Expected: the next LOAD follows immediately; second drain data correct.
- Reset mid-STREAM after 2 handshakes. Expected:
  - Outputs return immediately to their reset values.
  - No `done`.
  - The next `start` yields a full 4-word drain.
- Data integrity: tail lanes 0xFFFFFFFF/0x00000000/0x80000001/0x7FFFFFFE. Expected: bit-exact `out_data` packing, lane3 in the MSBs.
